ucore_dispatch: RTL and testbench
=================================

Name: ucore_dispatch

Overview:
Upstream job dispatcher for uCore, the vector micro-core.
- Accepts jobs from sensor/estimator logic over a valid/ready handshake and buffers them in a small FIFO. A job is three 18-bit X/Y/Z operand vectors A, B, C plus a 5-bit program start pointer.
- Launches uCore one job at a time: drives its operand inputs, instruction_start_pointer and a single-cycle run pulse.
- Waits for completion, captures the 54-bit result and hands it downstream over valid/ready. A hung program is flagged by timeout.

Parameters:
- DATA_W, 18, width of one vector component.
- PTR_W, 5, width of the uCore program start pointer.
- FIFO_DEPTH, 2, job buffer entries (power of two, ≥2).
- TIMEOUT_CYCLES, 200, maximum cycles in WAIT before an error completion (1..255).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  job offered.
- in_ready  out  1  job buffer can accept.
- in_a  in  54  operand A packed {X[53:36], Y[35:18], Z[17:0]}.
- in_b  in  54  operand B, same packing.
- in_c  in  54  operand C, same packing.
- in_ptr  in  5  program start pointer for this job.
- core_ready  in  1  uCore idle and able to start.
- core_done  in  1  one-cycle pulse; core_result valid this cycle.
- core_result  in  54  uCore result vector, same packing.
- core_run  out  1  start pulse to uCore.
- core_a / core_b / core_c  out  54 each  operands; split by the top level into input_A_X … input_C_Z.
- core_ptr  out  5  to instruction_start_pointer.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts.
- out_result  out  54  captured result.
- out_error  out  1  qualifies out_valid; 1 means the job timed out.
- busy  out  1  high when state ≠ IDLE or FIFO is non-empty.

Behaviour:
- Reset (async assert, sync deassert) sets:
  - state = IDLE; FIFO empty.
  - core_run = 0; core_a/b/c, core_ptr, out_result = 0.
  - out_valid = 0; out_error = 0; timeout counter = 0.
  - in_ready = 1 (in_ready = !fifo_full, decoded from registers).
- FIFO:
  - Push when in_valid & in_ready. Pop only from the IDLE launch.
  - A push into a full FIFO cannot occur: in_ready is low, even if a pop happens the same cycle.
  - Wrap-around uses log2(FIFO_DEPTH) pointers plus a count.
- IDLE: if the FIFO is non-empty and core_ready = 1:
  - Load core_a/b/c and core_ptr from the FIFO head, pop, go to RUN.
  - Otherwise remain in IDLE. core_ready = 0 stalls the dispatcher indefinitely.
- RUN:
  - core_run = 1 for exactly this cycle.
  - Clear the counter; go to WAIT.
- WAIT:
  - Operands and core_ptr are held stable. The counter increments each cycle.
  - core_done = 1: out_result ← core_result, out_error ← 0, out_valid ← 1, go to OUT.
  - Otherwise, counter == TIMEOUT_CYCLES−1: out_result ← 0, out_error ← 1, out_valid ← 1, go to OUT.
  - If core_done and the timeout coincide, core_done wins.
- OUT:
  - Hold out_valid, out_result and out_error until out_ready.
  - On out_valid & out_ready: clear out_valid and out_error next cycle, go to IDLE.
  - A new launch is possible in the cycle after that.
- core_done outside WAIT is ignored; no capture, no state change.
- Latency:
  - Job pushed at edge t into an empty FIFO with core_ready = 1 → core_run high in cycle t+2.
  - core_done in cycle d → out_valid high from cycle d+1.
- core_run is never asserted while out_valid = 1. At most one job is in flight.
- Reset asserted mid-job:
  - Immediately clears the FIFO, out_valid and core_run.
  - The in-flight job is dropped; no output is produced for it.

Decomposition:
- Shared package ucore_pkg:
  - Constants DATA_W, VEC_W = 3*DATA_W, PTR_W.
  - Field offsets X_LSB = 36, Y_LSB = 18, Z_LSB = 0.
  - State enum {IDLE, RUN, WAIT, OUT}.
- One sub-module: ucore_job_fifo. It stores 167-bit entries {a, b, c, ptr} and has ports push, pop, full, empty, head.

Test Plan:
1. Reset then single job: in_a = 0x0400_0_0008-style values, in_ptr = 5'h10, core_ready = 1 → core_run pulses once at t+2 with core_ptr = 5'h10 and core_a = in_a; core_done with result 54'h1 → out_valid next cycle, out_result = 1, out_error = 0.
2. Backpressure: push 3 jobs while core_ready = 0 → in_ready drops after 2 pushes; the 3rd is held until the first launch; jobs complete in push order (ptr 5'h0F, 5'h10, 5'h11).
3. Timeout: launch, never pulse core_done → after 200 WAIT cycles out_valid = 1, out_error = 1, out_result = 0; next job launches after out_ready.
4. Stalled output: out_ready = 0 for 10 cycles after completion → out_result stable, no core_run, a queued job waits; out_ready = 1 → job launches 2 cycles later.
5. Spurious core_done in IDLE and RUN → no out_valid, no state change.
6. rst asserted during WAIT with a queued job → next cycle FIFO empty, out_valid = 0, in_ready = 1, busy = 0; a later core_done is ignored.

Source files
------------

// File: rtl/ucore_pkg.sv
// Shared types and constants for the uCore job dispatcher.
// Vectors pack X/Y/Z components MSB-first into one word.
package ucore_pkg;

  localparam int DATA_W = 18;
  localparam int VEC_W  = 3 * DATA_W;
  localparam int PTR_W  = 5;
  localparam int CNT_W  = 8;

  localparam int X_LSB = 36;
  localparam int Y_LSB = 18;
  localparam int Z_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT,
    OUT
  } state_e;

  function automatic logic [VEC_W-1:0] vec_pack(
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] y,
    input logic [DATA_W-1:0] z
  );
    logic [VEC_W-1:0] v;
    v = '0;
    v[X_LSB +: DATA_W] = x;
    v[Y_LSB +: DATA_W] = y;
    v[Z_LSB +: DATA_W] = z;
    return v;
  endfunction

endpackage

// File: rtl/ucore_job_fifo.sv
// Small job buffer for the dispatcher: power-of-two depth,
// wrapping pointers plus an occupancy count.
module ucore_job_fifo #(
  parameter int W     = 167,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ucore_dispatch.sv
// Upstream job dispatcher: buffers jobs, launches uCore one at a
// time, captures its result (or a timeout) and hands it downstream.
module ucore_dispatch
  import ucore_pkg::*;
#(
  parameter int FIFO_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_a,
  input  logic [VEC_W-1:0] in_b,
  input  logic [VEC_W-1:0] in_c,
  input  logic [PTR_W-1:0] in_ptr,
  input  logic             core_ready,
  input  logic             core_done,
  input  logic [VEC_W-1:0] core_result,
  output logic             core_run,
  output logic [VEC_W-1:0] core_a,
  output logic [VEC_W-1:0] core_b,
  output logic [VEC_W-1:0] core_c,
  output logic [PTR_W-1:0] core_ptr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] out_result,
  output logic             out_error,
  output logic             busy
);

  localparam int JOB_W = 3 * VEC_W + PTR_W;

  state_e           state_q, state_d;
  logic [VEC_W-1:0] a_q, a_d;
  logic [VEC_W-1:0] b_q, b_d;
  logic [VEC_W-1:0] c_q, c_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [VEC_W-1:0] res_q, res_d;
  logic             ov_q, ov_d;
  logic             oe_q, oe_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             launch;
  logic             timeout;
  logic [JOB_W-1:0] head;

  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;
  assign launch   = (state_q == IDLE) & ~fifo_empty & core_ready;
  assign timeout  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  ucore_job_fifo #(
    .W     (JOB_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (launch),
    .wdata ({in_a, in_b, in_c, in_ptr}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // core_done wins over a coincident timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (launch) state_d = RUN;
      RUN:     state_d = WAIT;
      WAIT:    if (core_done || timeout) state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    core_run = (state_q == RUN);
    busy     = (state_q != IDLE) | ~fifo_empty;
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    ptr_d = ptr_q;
    res_d = res_q;
    ov_d  = ov_q;
    oe_d  = oe_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (launch) begin
          {a_d, b_d, c_d, ptr_d} = head;
        end
      end
      RUN: begin
        cnt_d = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (core_done) begin
          res_d = core_result;
          oe_d  = 1'b0;
          ov_d  = 1'b1;
        end else if (timeout) begin
          res_d = '0;
          oe_d  = 1'b1;
          ov_d  = 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          ov_d = 1'b0;
          oe_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      ptr_q <= '0;
      res_q <= '0;
      ov_q  <= 1'b0;
      oe_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      ptr_q <= ptr_d;
      res_q <= res_d;
      ov_q  <= ov_d;
      oe_q  <= oe_d;
      cnt_q <= cnt_d;
    end
  end

  assign core_a     = a_q;
  assign core_b     = b_q;
  assign core_c     = c_q;
  assign core_ptr   = ptr_q;
  assign out_valid  = ov_q;
  assign out_error  = oe_q;
  assign out_result = res_q;

endmodule

// File: tb/tb_ucore_dispatch.sv
// Directed bench for ucore_dispatch with a behavioural uCore
// and launch/result scoreboards.
module tb_ucore_dispatch;
  import ucore_pkg::*;

  typedef struct packed {
    logic [53:0] a;
    logic [53:0] b;
    logic [53:0] c;
    logic [4:0]  p;
  } job_t;

  typedef struct packed {
    logic        err;
    logic [53:0] res;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [53:0] in_a, in_b, in_c;
  logic [4:0]  in_ptr;
  logic        core_ready;
  logic        core_done;
  logic [53:0] core_result;
  logic        core_run;
  logic [53:0] core_a, core_b, core_c;
  logic [4:0]  core_ptr;
  logic        out_valid;
  logic        out_ready;
  logic [53:0] out_result;
  logic        out_error;
  logic        busy;

  logic        model_done;
  logic [53:0] model_res;
  logic        force_done;
  logic [53:0] force_res;
  logic        hang;
  int          pend;

  int n_chk;
  int n_fail;

  job_t launch_q[$];
  exp_t exp_q[$];

  assign core_done   = model_done | force_done;
  assign core_result = force_done ? force_res : model_res;

  ucore_dispatch dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_c        (in_c),
    .in_ptr      (in_ptr),
    .core_ready  (core_ready),
    .core_done   (core_done),
    .core_result (core_result),
    .core_run    (core_run),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_c      (core_c),
    .core_ptr    (core_ptr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_error   (out_error),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [53:0] core_fn(input job_t j);
    return j.a ^ {j.b[35:0], j.b[53:36]} ^ ~j.c ^ {49'd0, j.p};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input job_t j, input exp_t e);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_a     = j.a;
    in_b     = j.b;
    in_c     = j.c;
    in_ptr   = j.p;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    chk("push_wait_bound", (w < 50), 1'b1);
    launch_q.push_back(j);
    exp_q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || launch_q.size() != 0) && w < 400) begin
      tick();
      w++;
    end
    chk(tag, exp_q.size() + launch_q.size(), 0);
    tick();
  endtask

  // behavioural uCore: fixed 3-cycle latency unless hung
  always begin
    @(posedge clk);
    #1;
    model_done = 1'b0;
    if (rst) begin
      pend = 0;
    end else if (pend != 0) begin
      pend--;
      if (pend == 0) begin
        model_done = 1'b1;
        model_res  = core_fn('{core_a, core_b, core_c, core_ptr});
      end
    end else if (core_run && !hang) begin
      pend = 3;
    end
  end

  always @(negedge clk) begin
    if (!rst && core_run) begin
      chk("run_while_out_valid", out_valid, 1'b0);
      chk("run_expected", (launch_q.size() != 0), 1'b1);
      if (launch_q.size() != 0) begin
        job_t j;
        j = launch_q.pop_front();
        chk("launch_ptr", core_ptr, j.p);
        chk("launch_a", core_a, j.a);
        chk("launch_b", core_b, j.b);
        chk("launch_c", core_c, j.c);
      end
    end
    if (!rst && out_valid && out_ready) begin
      chk("out_expected", (exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_result", out_result, e.res);
        chk("out_error", out_error, e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    job_t j;
    n_chk      = 0;
    n_fail     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    in_c       = '0;
    in_ptr     = '0;
    core_ready = 1'b1;
    out_ready  = 1'b1;
    force_done = 1'b0;
    force_res  = '0;
    model_done = 1'b0;
    model_res  = '0;
    hang       = 1'b1;
    pend       = 0;

    tick();
    tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_core_run", core_run, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_error", out_error, 1'b0);
    chk("rst_out_result", out_result, 54'd0);
    chk("rst_core_a", core_a, 54'd0);
    chk("rst_core_ptr", core_ptr, 5'd0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // single job, forced completion with result 1
    j.a = vec_pack(18'h00400, 18'h00000, 18'h00008);
    j.b = vec_pack(18'h00001, 18'h00002, 18'h00003);
    j.c = vec_pack(18'h3FFFF, 18'h00010, 18'h20000);
    j.p = 5'h10;
    push_job(j, '{1'b0, 54'h1});
    chk("t1_run_t1", core_run, 1'b0);
    tick();
    chk("t1_run_t2", core_run, 1'b1);
    chk("t1_core_ptr", core_ptr, 5'h10);
    chk("t1_core_a", core_a, j.a);
    tick();
    chk("t1_run_single", core_run, 1'b0);
    chk("t1_wait_no_out", out_valid, 1'b0);
    force_done = 1'b1;
    force_res  = 54'h1;
    tick();
    force_done = 1'b0;
    chk("t1_out_valid", out_valid, 1'b1);
    chk("t1_out_result", out_result, 54'h1);
    chk("t1_out_error", out_error, 1'b0);
    tick();
    chk("t1_out_clear", out_valid, 1'b0);
    chk("t1_busy_idle", busy, 1'b0);

    // backpressure: three jobs while uCore is not ready
    hang       = 1'b0;
    core_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      j.a = vec_pack(18'(i * 7 + 1), 18'h12345, 18'(i));
      j.b = vec_pack(18'h0F0F0, 18'(i + 3), 18'h2AAAA);
      j.c = vec_pack(18'(i * 11), 18'h15555, 18'h00100);
      j.p = 5'(5'h0F + i);
      push_job(j, '{1'b0, core_fn(j)});
    end
    chk("t2_full", in_ready, 1'b0);
    j.a = vec_pack(18'h3C3C3, 18'h00777, 18'h1ABCD);
    j.b = vec_pack(18'h00042, 18'h2FFFF, 18'h00009);
    j.c = vec_pack(18'h11111, 18'h22222, 18'h33333);
    j.p = 5'h11;
    in_valid = 1'b1;
    in_a     = j.a;
    in_b     = j.b;
    in_c     = j.c;
    in_ptr   = j.p;
    repeat (3) tick();
    chk("t2_held_ready", in_ready, 1'b0);
    chk("t2_stall_run", core_run, 1'b0);
    chk("t2_busy", busy, 1'b1);
    core_ready = 1'b1;
    push_job(j, '{1'b0, core_fn(j)});
    drain("t2_drain");

    // spurious core_done in IDLE
    force_done = 1'b1;
    force_res  = 54'h3FF;
    tick();
    force_done = 1'b0;
    chk("t5_idle_out", out_valid, 1'b0);
    chk("t5_idle_busy", busy, 1'b0);

    // timeout job, spurious done in RUN, then stalled output
    hang      = 1'b1;
    out_ready = 1'b0;
    j.a = vec_pack(18'h00AAA, 18'h00BBB, 18'h00CCC);
    j.b = vec_pack(18'h00001, 18'h00001, 18'h00001);
    j.c = vec_pack(18'h00002, 18'h00002, 18'h00002);
    j.p = 5'h07;
    push_job(j, '{1'b1, 54'h0});
    tick();
    chk("t5_run", core_run, 1'b1);
    force_done = 1'b1;
    force_res  = 54'h155;
    tick();
    force_done = 1'b0;
    chk("t5_run_spur_out", out_valid, 1'b0);
    chk("t5_run_spur_run", core_run, 1'b0);
    j.a = vec_pack(18'h01234, 18'h05678, 18'h09ABC);
    j.b = vec_pack(18'h3FFFE, 18'h00000, 18'h10001);
    j.c = vec_pack(18'h0DEAD, 18'h0BEEF, 18'h0CAFE);
    j.p = 5'h1F;
    push_job(j, '{1'b0, core_fn(j)});
    hang = 1'b0;
    repeat (198) tick();
    chk("t3_before_timeout", out_valid, 1'b0);
    tick();
    chk("t3_out_valid", out_valid, 1'b1);
    chk("t3_out_error", out_error, 1'b1);
    chk("t3_out_result", out_result, 54'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_valid", out_valid, 1'b1);
      chk("t4_hold_result", out_result, 54'h0);
      chk("t4_hold_norun", core_run, 1'b0);
    end
    chk("t4_queued", busy, 1'b1);
    out_ready = 1'b1;
    tick();
    chk("t4_gap_out", out_valid, 1'b0);
    chk("t4_gap_run", core_run, 1'b0);
    tick();
    chk("t4_launch", core_run, 1'b1);
    drain("t4_drain");

    // reset mid-job with a queued job
    hang = 1'b1;
    j.a = vec_pack(18'h00011, 18'h00022, 18'h00033);
    j.b = '0;
    j.c = '0;
    j.p = 5'h02;
    push_job(j, '{1'b0, 54'h0});
    j.p = 5'h03;
    push_job(j, '{1'b0, 54'h0});
    tick();
    tick();
    chk("t6_busy_before", busy, 1'b1);
    rst = 1'b1;
    launch_q.delete();
    exp_q.delete();
    #1;
    chk("t6_async_out", out_valid, 1'b0);
    chk("t6_async_ready", in_ready, 1'b1);
    chk("t6_async_busy", busy, 1'b0);
    tick();
    chk("t6_out_valid", out_valid, 1'b0);
    chk("t6_in_ready", in_ready, 1'b1);
    chk("t6_busy", busy, 1'b0);
    chk("t6_core_run", core_run, 1'b0);
    rst = 1'b0;
    tick();
    force_done = 1'b1;
    force_res  = 54'h2A;
    tick();
    force_done = 1'b0;
    chk("t6_late_done", out_valid, 1'b0);
    tick();
    chk("t6_no_relaunch", core_run, 1'b0);
    chk("t6_idle", busy, 1'b0);
    chk("end_queues", exp_q.size() + launch_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
